// File: rtl/fractal_sync_node.sv
// One N-ary node of the fractal synchronization tree: collects child sync requests,
// resolves barriers at NODE_LVL locally and forwards higher-level barriers to the parent.
module fractal_sync_node #(
  parameter int unsigned N_CHILDREN = 2,
  parameter int unsigned LVL_WIDTH  = 4,
  parameter int unsigned NODE_LVL   = 1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic [N_CHILDREN-1:0]           chd_sync_i,
  input  logic [N_CHILDREN*LVL_WIDTH-1:0] chd_level_i,
  output logic [N_CHILDREN-1:0]           chd_wake_o,
  output logic [N_CHILDREN-1:0]           chd_error_o,
  input  logic [N_CHILDREN-1:0]           chd_ack_i,
  output logic                            par_sync_o,
  output logic [LVL_WIDTH-1:0]            par_level_o,
  input  logic                            par_wake_i,
  input  logic                            par_error_i,
  output logic                            par_ack_o
);

  localparam logic [LVL_WIDTH-1:0] NODE_LVL_V = LVL_WIDTH'(NODE_LVL);

  typedef enum logic [1:0] {S_IDLE, S_PEND, S_WAKE, S_ERR} slot_t;
  typedef enum logic {N_COLLECT, N_UP_WAIT} node_t;

  slot_t slot_q [N_CHILDREN];
  slot_t slot_d [N_CHILDREN];
  node_t node_q, node_d;

  logic [LVL_WIDTH-1:0]  grp_q, grp_d;
  logic [LVL_WIDTH-1:0]  first_lvl, eff_lvl;
  logic [LVL_WIDTH-1:0]  par_level_q, par_level_d;
  logic [N_CHILDREN-1:0] cap, cap_ok, pend_now, pend_nxt;
  logic [N_CHILDREN-1:0] wake_q, wake_d, err_q, err_d;
  logic                  any_cap, all_pend;
  logic                  par_sync_q, par_sync_d, par_ack_q, par_ack_d;

  // Completion is judged on the pending set *after* this cycle's captures, so the
  // barrier resolves one cycle after the last sync rather than two.
  always_comb begin
    cap       = '0;
    pend_now  = '0;
    cap_ok    = '0;
    first_lvl = grp_q;
    for (int unsigned i = 0; i < N_CHILDREN; i++) begin
      cap[i]      = chd_sync_i[i] && (slot_q[i] == S_IDLE);
      pend_now[i] = (slot_q[i] == S_PEND);
    end
    for (int unsigned k = 0; k < N_CHILDREN; k++) begin
      if (cap[N_CHILDREN-1-k])
        first_lvl = chd_level_i[(N_CHILDREN-1-k)*LVL_WIDTH +: LVL_WIDTH];
    end
    any_cap = |cap;
    eff_lvl = (pend_now == '0 && any_cap) ? first_lvl : grp_q;
    for (int unsigned i = 0; i < N_CHILDREN; i++) begin
      cap_ok[i] = cap[i]
                  && (chd_level_i[i*LVL_WIDTH +: LVL_WIDTH] >= NODE_LVL_V)
                  && (chd_level_i[i*LVL_WIDTH +: LVL_WIDTH] == eff_lvl);
    end
    pend_nxt = pend_now | cap_ok;
    all_pend = &pend_nxt;
  end

  always_comb begin
    node_d      = node_q;
    grp_d       = eff_lvl;
    par_sync_d  = 1'b0;
    par_ack_d   = 1'b0;
    par_level_d = par_level_q;
    for (int unsigned i = 0; i < N_CHILDREN; i++) begin
      slot_d[i] = slot_q[i];
      case (slot_q[i])
        S_IDLE: if (cap[i]) slot_d[i] = cap_ok[i] ? S_PEND : S_ERR;
        S_WAKE,
        S_ERR:  if (chd_ack_i[i]) slot_d[i] = S_IDLE;
        default: ;
      endcase
    end
    case (node_q)
      N_COLLECT: begin
        if (all_pend) begin
          if (eff_lvl == NODE_LVL_V) begin
            for (int unsigned i = 0; i < N_CHILDREN; i++) slot_d[i] = S_WAKE;
          end else begin
            node_d      = N_UP_WAIT;
            par_sync_d  = 1'b1;
            par_level_d = eff_lvl;
          end
        end
      end
      N_UP_WAIT: begin
        if (par_error_i || par_wake_i) begin
          for (int unsigned i = 0; i < N_CHILDREN; i++)
            slot_d[i] = par_error_i ? S_ERR : S_WAKE;
          node_d      = N_COLLECT;
          par_ack_d   = 1'b1;
          par_level_d = '0;
        end
      end
      default: node_d = N_COLLECT;
    endcase
    for (int unsigned i = 0; i < N_CHILDREN; i++) begin
      wake_d[i] = (slot_d[i] == S_WAKE);
      err_d[i]  = (slot_d[i] == S_ERR);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < N_CHILDREN; i++) slot_q[i] <= S_IDLE;
      node_q      <= N_COLLECT;
      grp_q       <= '0;
      par_level_q <= '0;
      par_sync_q  <= 1'b0;
      par_ack_q   <= 1'b0;
      wake_q      <= '0;
      err_q       <= '0;
    end else begin
      for (int unsigned i = 0; i < N_CHILDREN; i++) slot_q[i] <= slot_d[i];
      node_q      <= node_d;
      grp_q       <= grp_d;
      par_level_q <= par_level_d;
      par_sync_q  <= par_sync_d;
      par_ack_q   <= par_ack_d;
      wake_q      <= wake_d;
      err_q       <= err_d;
    end
  end

  assign chd_wake_o  = wake_q;
  assign chd_error_o = err_q;
  assign par_sync_o  = par_sync_q;
  assign par_level_o = par_level_q;
  assign par_ack_o   = par_ack_q;

endmodule

// File: doc/fractal_sync_node.md
Name: fractal_sync_node

Overview:
- One N-ary node of the fractal synchronization tree.
- Collects sync requests from N_CHILDREN child ports, each carrying sync/level/wake/error/ack.
- Resolves a barrier locally when the requested level equals NODE_LVL; otherwise forwards one aggregated request to the parent port and broadcasts the parent's answer back down.
- Instantiated recursively between leaf cores and root nodes; successor to the single-channel fractal sync link.

Parameters:
- N_CHILDREN, 2, number of child ports (>=2).
- LVL_WIDTH, 4, width of the level field.
- NODE_LVL, 1, tree level resolved by this node (1..2^LVL_WIDTH-1).

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  synchronous active-high reset.
- chd_sync_i  input  N_CHILDREN  per-child one-cycle sync request pulse.
- chd_level_i  input  N_CHILDREN*LVL_WIDTH  per-child level; child i occupies bits [i*LVL_WIDTH +: LVL_WIDTH]; sampled with sync.
- chd_wake_o  output  N_CHILDREN  per-child wake, held until ack.
- chd_error_o  output  N_CHILDREN  per-child error, held until ack.
- chd_ack_i  input  N_CHILDREN  per-child one-cycle acknowledge of wake/error.
- par_sync_o  output  1  one-cycle sync pulse to parent.
- par_level_o  output  LVL_WIDTH  level forwarded to parent; valid with par_sync_o, held until the parent answers.
- par_wake_i  input  1  parent grant.
- par_error_i  input  1  parent error.
- par_ack_o  output  1  one-cycle ack to parent.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i. All state and outputs are registered.
- Reset values: all outputs 0; every child slot IDLE; node FSM COLLECT; group level cleared.
- Reset mid-operation: all pending, wake and error state is dropped; an outstanding parent request is abandoned with no ack sent.

Per-child slot FSM:
- IDLE, PEND, WAKE, ERR.
- IDLE + sync -> PEND or ERR (see level rules).
- WAKE/ERR + ack -> IDLE; wake/error deasserts the cycle after ack.
- Sync received in PEND, WAKE or ERR is dropped. No state change.
- Ack received in IDLE or PEND is ignored.

Level rules, applied at sync capture:
- Group level: set when the pending set is empty, to the level of the lowest-index child syncing that cycle.
- Child level < NODE_LVL -> ERR next cycle.
- Child level != group level while the pending set is non-empty or another child is being captured -> ERR next cycle.
- Otherwise -> PEND.

Node FSM: COLLECT, UP_WAIT.
- COLLECT, all N slots PEND, group level == NODE_LVL: every slot goes to WAKE; chd_wake_o rises one cycle after the last sync; stay in COLLECT.
- COLLECT, all N slots PEND, group level > NODE_LVL: par_sync_o pulses for one cycle, one cycle after the last sync, with par_level_o = group level; go to UP_WAIT.
- UP_WAIT, par_wake_i: all slots -> WAKE; par_ack_o pulses. Both take effect the next cycle. Return to COLLECT.
- UP_WAIT, par_error_i: all slots -> ERR; par_ack_o pulses. Both take effect the next cycle. Return to COLLECT.
- UP_WAIT, par_wake_i and par_error_i together: error wins.
- In UP_WAIT every slot is PEND, so no child sync can be accepted.

Other rules:
- Simultaneous ack by child j and sync by child k in the same cycle are processed independently.
- A child that has acked may sync again while its peers are still in WAKE; this starts a new group.
- Level field arithmetic is unsigned.

Test Plan:
- N=2, NODE_LVL=1: child0 sync lvl1 at t0, child1 sync lvl1 at t3 -> chd_wake_o=2'b11 at t4; ack0 at t6 -> wake0=0 at t7; wake1 held until ack1.
- N=4, NODE_LVL=1: all four sync lvl3 in the same cycle t0 -> par_sync_o=1, par_level_o=3 at t1 only; no child wake; par_wake_i at t5 -> chd_wake_o=4'hF and par_ack_o=1 at t6.
- Child0 sync lvl1, then child1 sync lvl2 -> chd_error_o[1]=1 the next cycle; child0 stays PEND; child1 acks then syncs lvl1 -> both wake.
- NODE_LVL=2: child sync lvl1 -> error the next cycle. Separately, parent asserts par_wake_i and par_error_i together -> all children get error, par_ack_o=1.
- Duplicate sync from a PEND child is dropped (barrier still requires all N). Assert rst_i during UP_WAIT -> the next cycle all outputs are 0, and a fresh barrier completes normally.
